// File: rtl/down_counter_mod16_pkg.sv
// Shared definitions for the programmable down-counter/timer.
// The default width is shared with the mod-16 up-counter.
package down_counter_mod16_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_mod16_if.sv
// Control/status bundle of the down-counter: the master issues commands,
// the slave (the counter) reports count, busy and the terminal-count pulse.
interface down_counter_mod16_if
  import down_counter_mod16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             periodic;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  modport master (
    output start, load_value, periodic, pause, stop,
    input  count, busy, tc
  );

  modport slave (
    input  start, load_value, periodic, pause, stop,
    output count, busy, tc
  );

endinterface

// File: rtl/down_counter_mod16.sv
// Programmable down-counter/timer with one-shot and auto-reload modes.
// tc is a one-cycle Moore pulse in DONE; busy is high throughout RUN.
module down_counter_mod16
  import down_counter_mod16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  down_counter_mod16_if.slave   bus
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             mode_reg, mode_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      mode_reg   <= mode_next;
    end
  end

  // Priority: stop, then start, then pause, then normal counting.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    mode_next   = mode_reg;

    if (bus.stop) begin
      state_next = IDLE;
    end else if (bus.start) begin
      count_next  = bus.load_value;
      reload_next = bus.load_value;
      if (bus.load_value != '0) begin
        mode_next  = bus.periodic;
        state_next = RUN;
      end else begin
        // A zero load is always one-shot so it cannot retrigger forever.
        mode_next  = 1'b0;
        state_next = DONE;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (!bus.pause) begin
            if (count_reg == WIDTH'(1)) begin
              count_next = '0;
              state_next = DONE;
            end else begin
              count_next = count_reg - WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (mode_reg) begin
            count_next = reload_reg;
            state_next = RUN;
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = (state_reg == RUN);
  assign bus.tc    = (state_reg == DONE);

endmodule
